// File: rtl/vecmac_dot_acc_if.sv
// Valid/ready bundle for the dot-product engine: the operand beat stream in,
// the accumulated result stream out.
interface vecmac_dot_acc_if #(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int ACC_W = 2*8 + 2 + 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_first;
  logic                 in_last;
  logic                 in_signed;
  logic [LANES*W-1:0]   in_a;
  logic [LANES*W-1:0]   in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_acc;
  logic                 out_ovf;

  modport master (
    output in_valid, in_first, in_last, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/vecmac_dot_acc.sv
// LANES x (W x W) multiply, lane-sum and frame accumulate engine.
// Three stages (products, lane sum, accumulate) with a single global stall.
module vecmac_dot_acc #(
  parameter int LANES   = 4,
  parameter int W       = 8,
  parameter int ACC_EXT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  vecmac_dot_acc_if.slave bus
);
  localparam int ACC_W = 2*W + $clog2(LANES) + ACC_EXT;
  localparam int PW    = 2*W;

  logic stall, accept, beat_signed, frame_signed;

  logic          s1_valid, s1_first, s1_last, s1_signed;
  logic [PW-1:0] s1_prod [LANES];
  logic [PW-1:0] prod_c  [LANES];
  logic [PW-1:0] ext_a   [LANES];
  logic [PW-1:0] ext_b   [LANES];

  logic             s2_valid, s2_first, s2_last, s2_signed;
  logic [ACC_W-1:0] s2_sum, sum_c;

  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W:0]   add_c;
  logic             ovf_r, ovf_nxt, wrap;

  logic             out_valid_r, out_ovf_r;
  logic [ACC_W-1:0] out_acc_r;

  assign stall         = out_valid_r && !bus.out_ready;
  assign accept        = bus.in_valid && !stall;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_r;
  assign bus.out_acc   = out_acc_r;
  assign bus.out_ovf   = out_ovf_r;

  // Mode comes from the current beat only when it opens a frame.
  assign beat_signed = bus.in_first ? bus.in_signed : frame_signed;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      ext_a[i]  = {{W{beat_signed & bus.in_a[i*W+W-1]}}, bus.in_a[i*W +: W]};
      ext_b[i]  = {{W{beat_signed & bus.in_b[i*W+W-1]}}, bus.in_b[i*W +: W]};
      prod_c[i] = ext_a[i] * ext_b[i];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_c = sum_c + {{(ACC_W-PW){s1_signed & s1_prod[i][PW-1]}}, s1_prod[i]};
    end
  end

  // Signed wrap: equal addend signs with a differing result sign.
  always_comb begin
    add_c   = {1'b0, acc} + {1'b0, s2_sum};
    wrap    = s2_signed ? ((acc[ACC_W-1] == s2_sum[ACC_W-1]) &&
                           (add_c[ACC_W-1] != acc[ACC_W-1]))
                        : add_c[ACC_W];
    acc_nxt = s2_first ? s2_sum : add_c[ACC_W-1:0];
    ovf_nxt = s2_first ? 1'b0 : (ovf_r | wrap);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_signed <= 1'b0;
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_signed    <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) s1_prod[i] <= '0;
      s2_valid     <= 1'b0;
      s2_first     <= 1'b0;
      s2_last      <= 1'b0;
      s2_signed    <= 1'b0;
      s2_sum       <= '0;
      acc          <= '0;
      ovf_r        <= 1'b0;
      out_valid_r  <= 1'b0;
      out_acc_r    <= '0;
      out_ovf_r    <= 1'b0;
    end else if (!stall) begin
      if (accept && bus.in_first) frame_signed <= bus.in_signed;
      s1_valid  <= accept;
      s1_first  <= bus.in_first;
      s1_last   <= bus.in_last;
      s1_signed <= beat_signed;
      s1_prod   <= prod_c;

      s2_valid  <= s1_valid;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      s2_signed <= s1_signed;
      s2_sum    <= sum_c;

      if (s2_valid) begin
        acc   <= acc_nxt;
        ovf_r <= ovf_nxt;
      end
      if (s2_valid && s2_last) begin
        out_valid_r <= 1'b1;
        out_acc_r   <= acc_nxt;
        out_ovf_r   <= ovf_nxt;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vecmac_dot_acc.sv
// Bench for vecmac_dot_acc: directed literal cases plus randomized frames
// checked every cycle against a frame-level arithmetic model.
module tb_vecmac_dot_acc;
  localparam int     LANES  = 4;
  localparam int     W      = 8;
  localparam int     ACC_W  = 26;
  localparam int     ACC_W0 = 18;
  localparam longint MOD    = longint'(1) << ACC_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vecmac_dot_acc_if #(.LANES(LANES), .W(W), .ACC_W(ACC_W))  bus ();
  vecmac_dot_acc_if #(.LANES(LANES), .W(W), .ACC_W(ACC_W0)) bus0 ();

  vecmac_dot_acc #(.LANES(LANES), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  vecmac_dot_acc #(.LANES(LANES), .W(W), .ACC_EXT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  int  checks = 0;
  int  fails  = 0;
  bit  check_en = 1'b0;
  bit  rand_ready = 1'b0, fix_ready = 1'b1, rr = 1'b1;

  assign bus.out_ready  = rand_ready ? rr : fix_ready;
  assign bus0.out_ready = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int cnt; longint acc; bit ovf; } pend_t;
  pend_t  pend[$];
  longint m_acc = 0, m_out_acc = 0;
  bit     m_ovf = 0, m_sgn = 0, m_out_valid = 0, m_out_ovf = 0, loaded;

  bit          s_rst = 0, s_valid = 0, s_first = 0, s_last = 0, s_sgn = 0, s_ready_o = 0;
  logic [31:0] s_a = '0, s_b = '0;

  function automatic longint beat_sum(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint t = 0, x, y;
    for (int i = 0; i < LANES; i++) begin
      x = a[i*8 +: 8];
      y = b[i*8 +: 8];
      if (sgn) begin
        if (x > 127) x -= 256;
        if (y > 127) y -= 256;
      end
      t += x * y;
    end
    return t;
  endfunction

  task automatic model_beat();
    longint s, as, t;
    if (s_first) m_sgn = s_sgn;
    s = beat_sum(m_sgn, s_a, s_b);
    if (s_first) begin
      m_acc = ((s % MOD) + MOD) % MOD;
      m_ovf = 1'b0;
    end else if (!m_sgn) begin
      t = m_acc + s;
      if (t >= MOD) m_ovf = 1'b1;
      m_acc = t % MOD;
    end else begin
      as = (m_acc >= MOD/2) ? m_acc - MOD : m_acc;
      t  = as + s;
      if (t >= MOD/2 || t < -(MOD/2)) m_ovf = 1'b1;
      m_acc = ((t % MOD) + MOD) % MOD;
    end
    if (s_last) pend.push_back(pend_t'{2, m_acc, m_ovf});
  endtask

  always @(posedge clk) begin
    if (!s_rst) begin
      m_acc = 0; m_ovf = 0; m_sgn = 0;
      m_out_valid = 0; m_out_acc = 0; m_out_ovf = 0;
      pend.delete();
    end else if (!(m_out_valid && !s_ready_o)) begin
      loaded = 1'b0;
      foreach (pend[i]) begin
        pend[i].cnt--;
        if (pend[i].cnt == 0) begin
          loaded = 1'b1; m_out_acc = pend[i].acc; m_out_ovf = pend[i].ovf;
        end
      end
      while (pend.size() > 0 && pend[0].cnt == 0) void'(pend.pop_front());
      m_out_valid = loaded;
      if (s_valid) model_beat();
    end
  end

  // Compare, then sample what the next edge will see.
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", longint'(bus.in_ready), longint'(!(m_out_valid && !bus.out_ready)));
      chk("out_valid", longint'(bus.out_valid), longint'(m_out_valid));
      if (m_out_valid) begin
        chk("out_acc", longint'(bus.out_acc), m_out_acc);
        chk("out_ovf", longint'(bus.out_ovf), longint'(m_out_ovf));
      end
    end
    s_rst = rst_n; s_valid = bus.in_valid; s_first = bus.in_first;
    s_last = bus.in_last; s_sgn = bus.in_signed; s_ready_o = bus.out_ready;
    s_a = bus.in_a; s_b = bus.in_b;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input bit f, input bit l, input bit s,
                           input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    bus.in_valid = 1'b1; bus.in_first = f; bus.in_last = l;
    bus.in_signed = s; bus.in_a = a; bus.in_b = b;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!m_out_valid || bus.out_ready) begin ok = 1'b1; break; end
    end
    chk("beat accepted", longint'(ok), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input longint acc, input bit ovf,
                            input int exp_wait, input int max_wait);
    bit seen = 1'b0;
    int n;
    for (n = 0; n <= max_wait; n++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    chk({name, " seen"}, longint'(seen), 1);
    if (seen) begin
      if (exp_wait >= 0) chk({name, " latency"}, longint'(n), longint'(exp_wait));
      chk({name, " acc"}, longint'(bus.out_acc), acc);
      chk({name, " ovf"}, longint'(bus.out_ovf), longint'(ovf));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      rr = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0; bus.in_signed = 0;
    bus.in_a = '0; bus.in_b = '0;
    bus0.in_valid = 0; bus0.in_first = 0; bus0.in_last = 0; bus0.in_signed = 0;
    bus0.in_a = '0; bus0.in_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset out_valid", longint'(bus.out_valid), 0);
    chk("reset in_ready", longint'(bus.in_ready), 1);
    chk("reset dut0 out_valid", longint'(bus0.out_valid), 0);
    chk("reset dut0 in_ready", longint'(bus0.in_ready), 1);
    @(posedge clk); #1;

    // Narrow accumulator: two full-scale unsigned beats wrap.
    bus0.in_valid = 1; bus0.in_first = 1; bus0.in_last = 0; bus0.in_signed = 0;
    bus0.in_a = {4{8'hFF}}; bus0.in_b = {4{8'hFF}};
    @(posedge clk); #1 bus0.in_first = 0; bus0.in_last = 1;
    @(posedge clk); #1 bus0.in_first = 1; bus0.in_a = {4{8'h01}}; bus0.in_b = {4{8'h01}};
    @(posedge clk); #1 bus0.in_valid = 0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus0.out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    chk("t5 seen", longint'(seen), 1);
    chk("t5 acc", longint'(bus0.out_acc), 258056);
    chk("t5 ovf", longint'(bus0.out_ovf), 1);
    @(negedge clk);
    chk("t5b valid", longint'(bus0.out_valid), 1);
    chk("t5b acc", longint'(bus0.out_acc), 4);
    chk("t5b ovf", longint'(bus0.out_ovf), 0);
    @(posedge clk); #1;

    send_beat(1, 1, 0, {4{8'hFF}}, {4{8'hFF}});
    expect_out("t1", 260100, 0, 2, 10);
    send_beat(1, 1, 1, {4{8'h80}}, {4{8'h80}});
    expect_out("t2a", 65536, 0, 2, 10);
    send_beat(1, 1, 1, {4{8'hFF}}, {4{8'h01}});
    expect_out("t2b", 67108860, 0, 2, 10);

    send_beat(1, 0, 0, {4{8'd1}}, {4{8'd2}});
    send_beat(0, 0, 1, {4{8'd1}}, {4{8'd2}});
    send_beat(0, 1, 1, {4{8'd1}}, {4{8'd2}});
    send_beat(1, 1, 0, {4{8'd3}}, {4{8'd3}});
    expect_out("t3a", 24, 0, 1, 10);
    expect_out("t3b", 36, 0, 0, 0);

    fix_ready = 1'b0;
    fork
      begin
        send_beat(1, 1, 0, {4{8'd2}}, {4{8'd5}});
        send_beat(1, 1, 0, {4{8'd1}}, {4{8'd7}});
        send_beat(1, 1, 0, {4{8'd4}}, {4{8'd4}});
        send_beat(1, 1, 0, {4{8'd1}}, {4{8'd1}});
      end
      begin
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          if (bus.out_valid === 1'b1) begin seen = 1'b1; break; end
        end
        chk("t4 pending seen", longint'(seen), 1);
        for (int n = 0; n < 5; n++) begin
          @(negedge clk);
          chk("t4 held acc", longint'(bus.out_acc), 40);
          chk("t4 in_ready low", longint'(bus.in_ready), 0);
        end
        @(posedge clk); #1 fix_ready = 1'b1;
        expect_out("t4 r0", 40, 0, 0, 0);
        expect_out("t4 r1", 28, 0, 0, 0);
        expect_out("t4 r2", 64, 0, 0, 0);
        expect_out("t4 r3", 4, 0, 0, 0);
      end
    join

    send_beat(1, 0, 0, {4{8'h11}}, {4{8'h22}});
    send_beat(0, 1, 0, {4{8'h11}}, {4{8'h22}});
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("t6 out_valid", longint'(bus.out_valid), 0);
      chk("t6 in_ready", longint'(bus.in_ready), 1);
    end
    @(posedge clk); #1;
    send_beat(0, 1, 1, {4{8'd1}}, {4{8'd3}});
    expect_out("t6 nonfirst", 12, 0, 2, 10);
    send_beat(1, 1, 0, {4{8'd5}}, {4{8'd6}});
    expect_out("t6 fresh", 120, 0, 2, 10);

    rand_ready = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int unsigned len;
      bit sg;
      len = $urandom_range(1, 4);
      sg  = ($urandom_range(0, 1) == 1);
      for (int unsigned j = 0; j < len; j++) begin
        send_beat(j == 0, j == len - 1,
                  (j == 0) ? sg : ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 7) == 0) ? 32'h80808080 : $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'h7F80FF01 : $urandom);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    end
    rand_ready = 1'b0;
    fix_ready  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
